// File: rtl/ir_encoder_if.sv
// Request and response bundle between the instruction injector, ir_encoder and fetch.
interface ir_encoder_if #(parameter int DEPTH = 4);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic             req_valid;
    logic             req_ready;
    logic [6:0]       req_opcode;
    logic [2:0]       req_funct3;
    logic [6:0]       req_funct7;
    logic [4:0]       req_rd;
    logic [4:0]       req_rs1;
    logic [4:0]       req_rs2;
    logic [31:0]      req_imm;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_instr;
    logic             out_err;
    logic [CNT_W-1:0] count;

    modport master (
        output req_valid, req_opcode, req_funct3, req_funct7,
               req_rd, req_rs1, req_rs2, req_imm, out_ready,
        input  req_ready, out_valid, out_instr, out_err, count
    );

    modport slave (
        input  req_valid, req_opcode, req_funct3, req_funct7,
               req_rd, req_rs1, req_rs2, req_imm, out_ready,
        output req_ready, out_valid, out_instr, out_err, count
    );
endinterface

// File: rtl/ir_encoder.sv
// RV32I field-to-word encoder feeding an output FIFO of DEPTH entries.
// Define ENC_CHECK_EN to flag out-of-range fields and unknown opcodes on out_err.
module ir_encoder #(
    parameter int DEPTH = 4
) (
    input logic        clk,
    input logic        rst,
    ir_encoder_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_IMM   = 7'b0010011;
    localparam logic [6:0] OP_REG   = 7'b0110011;

    logic [31:0] imm;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic        is_shift;
    logic [31:0] enc_instr;
    logic        enc_err;

    assign imm      = bus.req_imm;
    assign op       = bus.req_opcode;
    assign f3       = bus.req_funct3;
    assign is_shift = (f3 == 3'b001) || (f3 == 3'b101);

    always_comb begin
        enc_instr = 32'h0000_0013;
        case (op)
            OP_LUI, OP_AUIPC:
                enc_instr = {imm[31:12], bus.req_rd, op};
            OP_JAL:
                enc_instr = {imm[20], imm[10:1], imm[11], imm[19:12], bus.req_rd, op};
            OP_JALR, OP_LOAD:
                enc_instr = {imm[11:0], bus.req_rs1, f3, bus.req_rd, op};
            OP_IMM:
                if (is_shift)
                    enc_instr = {bus.req_funct7, imm[4:0], bus.req_rs1, f3, bus.req_rd, op};
                else
                    enc_instr = {imm[11:0], bus.req_rs1, f3, bus.req_rd, op};
            OP_STORE:
                enc_instr = {imm[11:5], bus.req_rs2, bus.req_rs1, f3, imm[4:0], op};
            OP_BR:
                enc_instr = {imm[12], imm[10:5], bus.req_rs2, bus.req_rs1, f3,
                             imm[4:1], imm[11], op};
            OP_REG:
                enc_instr = {bus.req_funct7, bus.req_rs2, bus.req_rs1, f3, bus.req_rd, op};
            default:
                enc_instr = 32'h0000_0013;
        endcase
    end

`ifdef ENC_CHECK_EN
    // A value fits an N-bit signed field when all bits from N-1 upward agree.
    logic fits12, fits13, fits21;
    assign fits12 = (imm[31:11] == '0) || (imm[31:11] == '1);
    assign fits13 = (imm[31:12] == '0) || (imm[31:12] == '1);
    assign fits21 = (imm[31:20] == '0) || (imm[31:20] == '1);

    always_comb begin
        enc_err = 1'b1;
        case (op)
            OP_LUI, OP_AUIPC:          enc_err = (imm[11:0] != '0);
            OP_JAL:                    enc_err = !fits21 || imm[0];
            OP_JALR, OP_LOAD, OP_STORE: enc_err = !fits12;
            OP_IMM:                    enc_err = is_shift ? (imm[31:5] != '0) : !fits12;
            OP_BR:                     enc_err = !fits13 || imm[0];
            OP_REG:                    enc_err = 1'b0;
            default:                   enc_err = 1'b1;
        endcase
    end
`else
    assign enc_err = 1'b0;
`endif

    logic [32:0]      mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count_q;
    logic             full;
    logic             empty;
    logic             push;
    logic             pop;

    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);
    assign push  = bus.req_valid && !full;
    assign pop   = !empty && bus.out_ready;

    always_ff @(posedge clk) begin
        if (push && rst)
            mem[wr_ptr] <= {enc_err, enc_instr};
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)
                rd_ptr <= rd_ptr + PTR_W'(1);
            if (push && !pop)
                count_q <= count_q + CNT_W'(1);
            else if (pop && !push)
                count_q <= count_q - CNT_W'(1);
        end
    end

    assign bus.req_ready = !full;
    assign bus.out_valid = !empty;
    assign bus.out_instr = empty ? 32'h0 : mem[rd_ptr][31:0];
    assign bus.out_err   = empty ? 1'b0 : mem[rd_ptr][32];
    assign bus.count     = count_q;
endmodule

// File: tb/tb_ir_encoder.sv
// Scoreboard bench for ir_encoder: reference encoder model, random and directed requests.
module tb_ir_encoder;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;
    logic [32:0] exp_q [$];
    bit   rnd_ready = 0;

    ir_encoder_if #(.DEPTH(DEPTH)) bus ();
    ir_encoder #(.DEPTH(DEPTH)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: places fields by arithmetic shifts and judges ranges on signed integers.
    function automatic logic [32:0] model(input logic [6:0] op_l, input logic [2:0] f3_l,
                                          input logic [6:0] f7_l, input logic [4:0] rd_l,
                                          input logic [4:0] rs1_l, input logic [4:0] rs2_l,
                                          input logic [31:0] imm_l);
        int unsigned i   = imm_l;
        int          s   = $signed(imm_l);
        int unsigned op  = op_l;
        int unsigned f3  = f3_l;
        int unsigned f7  = f7_l;
        int unsigned rd  = rd_l;
        int unsigned rs1 = rs1_l;
        int unsigned rs2 = rs2_l;
        int unsigned w;
        bit          bad;
        case (op)
            'h37, 'h17: begin
                w   = (i & 'hFFFFF000) | (rd << 7) | op;
                bad = (i & 'hFFF) != 0;
            end
            'h6F: begin
                w = (((i >> 20) & 1) << 31) | (((i >> 1) & 'h3FF) << 21) |
                    (((i >> 11) & 1) << 20) | (((i >> 12) & 'hFF) << 12) | (rd << 7) | op;
                bad = s < -(1 << 20) || s > (1 << 20) - 1 || (i & 1) != 0;
            end
            'h67, 'h03: begin
                w   = ((i & 'hFFF) << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | op;
                bad = s < -2048 || s > 2047;
            end
            'h13: begin
                if (f3 == 1 || f3 == 5) begin
                    w   = (f7 << 25) | ((i & 'h1F) << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | op;
                    bad = (i >> 5) != 0;
                end else begin
                    w   = ((i & 'hFFF) << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | op;
                    bad = s < -2048 || s > 2047;
                end
            end
            'h23: begin
                w = (((i >> 5) & 'h7F) << 25) | (rs2 << 20) | (rs1 << 15) | (f3 << 12) |
                    ((i & 'h1F) << 7) | op;
                bad = s < -2048 || s > 2047;
            end
            'h63: begin
                w = (((i >> 12) & 1) << 31) | (((i >> 5) & 'h3F) << 25) | (rs2 << 20) |
                    (rs1 << 15) | (f3 << 12) | (((i >> 1) & 'hF) << 8) | (((i >> 11) & 1) << 7) | op;
                bad = s < -4096 || s > 4095 || (i & 1) != 0;
            end
            'h33: begin
                w   = (f7 << 25) | (rs2 << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | op;
                bad = 0;
            end
            default: begin
                w   = 'h13;
                bad = 1;
            end
        endcase
`ifdef ENC_CHECK_EN
        return {bad, w};
`else
        return {1'b0, w};
`endif
    endfunction

    task automatic issue(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                         input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [31:0] imm);
        bit done = 0;
        bus.req_opcode = op;
        bus.req_funct3 = f3;
        bus.req_funct7 = f7;
        bus.req_rd     = rd;
        bus.req_rs1    = rs1;
        bus.req_rs2    = rs2;
        bus.req_imm    = imm;
        bus.req_valid  = 1'b1;
        for (int k = 0; k < 200 && !done; k++) begin
            @(negedge clk);
            if (bus.req_ready) begin
                exp_q.push_back(model(op, f3, f7, rd, rs1, rs2, imm));
                done = 1;
            end
            @(posedge clk);
            #1;
            if (rnd_ready) bus.out_ready = ($urandom_range(0, 3) != 0);
        end
        bus.req_valid = 1'b0;
        if (!done) check("issue_timeout", 64'd0, 64'd1);
    endtask

    always @(negedge clk) begin
        if (rst && bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_output", {31'd0, bus.out_err, bus.out_instr}, 64'h1_0000_0000_0000);
            end else begin
                check("scoreboard", {31'd0, bus.out_err, bus.out_instr}, {31'd0, exp_q.pop_front()});
            end
        end
    end

    task automatic drain();
        bus.out_ready = 1'b1;
        for (int k = 0; k < 100 && bus.count != 0; k++) begin
            @(posedge clk);
            #1;
        end
        check("drained", {32'd0, exp_q.size()}, 64'd0);
    endtask

    initial begin
        logic [6:0]  ops [9] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h03, 7'h23, 7'h63, 7'h13, 7'h33};
        logic [6:0]  op;
        logic [31:0] imm;
        logic [32:0] e;

        bus.req_valid = 0; bus.req_opcode = 0; bus.req_funct3 = 0; bus.req_funct7 = 0;
        bus.req_rd = 0; bus.req_rs1 = 0; bus.req_rs2 = 0; bus.req_imm = 0; bus.out_ready = 0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        check("rst_count", {60'd0, bus.count}, 64'd0);
        check("rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
        check("rst_out_instr", {32'd0, bus.out_instr}, 64'd0);
        check("rst_out_err", {63'd0, bus.out_err}, 64'd0);
        check("rst_req_ready", {63'd0, bus.req_ready}, 64'd1);

        // Directed known words with the consumer always ready.
        bus.out_ready = 1'b1;
        issue(7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd5);
        check("addi_valid", {63'd0, bus.out_valid}, 64'd1);
        check("addi_word", {32'd0, bus.out_instr}, 64'h0050_0093);
        check("addi_err", {63'd0, bus.out_err}, 64'd0);
        issue(7'h37, 3'd0, 7'd0, 5'd3, 5'd0, 5'd0, 32'h1234_5000);
        check("lui_word", {32'd0, bus.out_instr}, 64'h1234_51B7);
        issue(7'h63, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, -32'sd4);
        check("beq_word", {32'd0, bus.out_instr}, 64'hFE20_8EE3);
        issue(7'h23, 3'd2, 7'd0, 5'd0, 5'd2, 5'd5, 32'd8);
        check("sw_word", {32'd0, bus.out_instr}, 64'h0051_2423);
        issue(7'h63, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, 32'd3);
        e = model(7'h63, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, 32'd2);
        check("br_odd_word", {32'd0, bus.out_instr}, {32'd0, e[31:0]});
`ifdef ENC_CHECK_EN
        check("br_odd_err", {63'd0, bus.out_err}, 64'd1);
`else
        check("br_odd_err", {63'd0, bus.out_err}, 64'd0);
`endif
        drain();

        // Fill to DEPTH with the consumer stalled; the fifth waits for space.
        bus.out_ready = 1'b0;
        for (int n = 0; n < DEPTH; n++)
            issue(7'h33, 3'(n), 7'h20, 5'(n + 1), 5'(n + 2), 5'(n + 3), 32'd0);
        check("full_count", {60'd0, bus.count}, 64'(DEPTH));
        check("full_ready", {63'd0, bus.req_ready}, 64'd0);
        bus.out_ready = 1'b1;
        issue(7'h33, 3'd7, 7'h00, 5'd9, 5'd10, 5'd11, 32'd0);
        drain();

        // Steady state at count=2: push and pop every cycle.
        bus.out_ready = 1'b0;
        issue(7'h13, 3'd0, 7'd0, 5'd4, 5'd4, 5'd0, 32'd100);
        issue(7'h13, 3'd0, 7'd0, 5'd5, 5'd5, 5'd0, 32'd200);
        bus.out_ready = 1'b1;
        for (int n = 0; n < 10; n++) begin
            issue(7'h13, 3'd4, 7'd0, 5'(n), 5'(n + 1), 5'd0, 32'(n * 7));
            check("steady_count", {60'd0, bus.count}, 64'd2);
        end
        drain();

        // Reset with three entries queued; a request during reset is dropped.
        bus.out_ready = 1'b0;
        for (int n = 0; n < 3; n++)
            issue(7'h03, 3'd2, 7'd0, 5'(n + 1), 5'd2, 5'd0, 32'(n * 4));
        check("pre_rst_count", {60'd0, bus.count}, 64'd3);
        rst = 1'b0;
        exp_q.delete();
        bus.req_opcode = 7'h33; bus.req_valid = 1'b1;
        @(posedge clk);
        #1 rst = 1'b1;
        bus.req_valid = 1'b0;
        check("mid_rst_valid", {63'd0, bus.out_valid}, 64'd0);
        check("mid_rst_count", {60'd0, bus.count}, 64'd0);
        check("mid_rst_ready", {63'd0, bus.req_ready}, 64'd1);
        issue(7'h67, 3'd0, 7'd0, 5'd1, 5'd6, 5'd0, 32'd16);
        e = model(7'h67, 3'd0, 7'd0, 5'd1, 5'd6, 5'd0, 32'd16);
        check("post_rst_count", {60'd0, bus.count}, 64'd1);
        check("post_rst_head", {32'd0, bus.out_instr}, {32'd0, e[31:0]});
        drain();

        // Random requests against the reference with a randomly stalling consumer.
        rnd_ready = 1;
        for (int n = 0; n < 300; n++) begin
            op = ($urandom_range(0, 9) == 9) ? 7'($urandom) : ops[$urandom_range(0, 8)];
            case ($urandom_range(0, 3))
                0: imm = 32'($urandom_range(0, 4095)) - 32'd2048;
                1: imm = $urandom;
                2: imm = ($urandom & 32'h1FFE) - 32'd4096;
                default: imm = $urandom & 32'h3F;
            endcase
            if (op == 7'h37 && $urandom_range(0, 1) == 1) imm = imm & 32'hFFFF_F000;
            issue(op, 3'($urandom), 7'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), imm);
            if ($urandom_range(0, 4) == 0) begin
                @(posedge clk);
                #1 bus.out_ready = ($urandom_range(0, 1) == 1);
            end
        end
        rnd_ready = 0;
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, vectors %0d", vectors);
        $fatal(1, "watchdog");
    end
endmodule
